// File: rtl/pulse_gen_pkg.sv
// Shared definitions for pulse_gen: FSM state encoding, the sampled request record
// and the minimum-length clamp applied to both pulse phases.
package pulse_gen_pkg;

    // Request fields are held at a fixed wide width; pulse_gen narrows them to CNT_W.
    localparam int unsigned PG_REQ_W = 32;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_HIGH,
        PG_LOW
    } pg_state_t;

    typedef struct packed {
        logic [PG_REQ_W-1:0] width;
        logic [PG_REQ_W-1:0] gap;
    } pg_req_t;

    function automatic logic [PG_REQ_W-1:0] pg_clamp(
        input logic [PG_REQ_W-1:0] len,
        input int unsigned         min_len
    );
        logic [PG_REQ_W-1:0] floor_len;
        floor_len = PG_REQ_W'(min_len);
        return (len < floor_len) ? floor_len : len;
    endfunction

endpackage

// File: rtl/pulse_gen.sv
// Strobe-to-pulse generator with guaranteed minimum high/low widths.
// Define PULSE_GEN_QUEUE_EN to add a one-deep request buffer; ports are unchanged.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MIN_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    output logic             signal,
    output logic             busy,
    output logic             done,
    output logic             drop
);

    pg_state_t        state;
    pg_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] gap_nx;
    logic             done_nx;
    logic             drop_nx;
    logic             cnt_last;
    logic             req_nz;
    pg_req_t          req;

`ifdef PULSE_GEN_QUEUE_EN
    pg_req_t          buf_q;
    pg_req_t          buf_nx;
    logic             buf_valid;
    logic             buf_valid_nx;
    logic             store;
`endif

    function automatic logic [CNT_W-1:0] phase_len(input logic [PG_REQ_W-1:0] len);
        return CNT_W'(pg_clamp(len, MIN_LEN));
    endfunction

    assign req      = {PG_REQ_W'(width), PG_REQ_W'(gap)};
    assign req_nz   = (width != '0);
    assign cnt_last = (cnt <= CNT_W'(1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gap_nx   = gap_q;
        done_nx  = 1'b0;
        drop_nx  = 1'b0;

`ifdef PULSE_GEN_QUEUE_EN
        buf_nx       = buf_q;
        buf_valid_nx = buf_valid;
        store        = start && (state != PG_IDLE) && !buf_valid && req_nz;
        if (store) begin
            buf_nx       = req;
            buf_valid_nx = 1'b1;
        end
        if (start && (state != PG_IDLE) && !store) begin
            drop_nx = 1'b1;
        end
`else
        if (start && (state != PG_IDLE)) begin
            drop_nx = 1'b1;
        end
`endif

        case (state)
            PG_IDLE: begin
                if (start) begin
                    if (req_nz) begin
                        state_nx = PG_HIGH;
                        cnt_nx   = phase_len(req.width);
                        gap_nx   = CNT_W'(req.gap);
                    end else begin
                        drop_nx = 1'b1;
                    end
                end
            end
            PG_HIGH: begin
                if (cnt_last) begin
                    state_nx = PG_LOW;
                    cnt_nx   = phase_len(PG_REQ_W'(gap_q));
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            PG_LOW: begin
                if (cnt_last) begin
`ifdef PULSE_GEN_QUEUE_EN
                    // A request stored in this very cycle launches directly
                    // instead of passing through an idle cycle.
                    if (buf_valid) begin
                        state_nx     = PG_HIGH;
                        cnt_nx       = phase_len(buf_q.width);
                        gap_nx       = CNT_W'(buf_q.gap);
                        buf_valid_nx = 1'b0;
                    end else if (store) begin
                        state_nx     = PG_HIGH;
                        cnt_nx       = phase_len(req.width);
                        gap_nx       = CNT_W'(req.gap);
                        buf_valid_nx = 1'b0;
                    end else begin
                        state_nx = PG_IDLE;
                        cnt_nx   = '0;
                    end
`else
                    state_nx = PG_IDLE;
                    cnt_nx   = '0;
`endif
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = PG_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= PG_IDLE;
            cnt    <= '0;
            gap_q  <= '0;
            signal <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            drop   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            gap_q  <= gap_nx;
            signal <= (state_nx == PG_HIGH);
            busy   <= (state_nx != PG_IDLE);
            done   <= done_nx;
            drop   <= drop_nx;
        end
    end

`ifdef PULSE_GEN_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            buf_valid <= 1'b0;
        end else begin
            buf_q     <= buf_nx;
            buf_valid <= buf_valid_nx;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: a vector table plus hand-written sequences feed
// a per-cycle scoreboard of expected {signal, busy, done, drop}.
module tb_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] width;
    logic [7:0] gap;
    logic       signal;
    logic       busy;
    logic       done;
    logic       drop;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [3:0]  v;
        int unsigned tag;
        int unsigned idx;
    } exp_t;

    typedef struct {
        logic [7:0]  w;
        logic [7:0]  g;
        int unsigned hi;
        int unsigned lo;
        logic        drp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    pulse_gen #(.CNT_W(8), .MIN_LEN(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .width  (width),
        .gap    (gap),
        .signal (signal),
        .busy   (busy),
        .done   (done),
        .drop   (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if ({signal, busy, done, drop} !== e.v) begin
                n_fail++;
                $display("FAIL seq%0d frame%0d: sig/busy/done/drop got %b want %b",
                         e.tag, e.idx, {signal, busy, done, drop}, e.v);
            end
        end
    end

    task automatic push(input logic [3:0] v, input int unsigned tag, input int unsigned idx);
        sb.push_back('{v: v, tag: tag, idx: idx});
    endtask

    // Frame 0 is the cycle start is driven; one idle frame closes each sequence.
    task automatic push_pulse(input int unsigned hi, input int unsigned lo,
                              input logic drp, input int unsigned tag);
        int unsigned k;
        k = 0;
        push(4'b0000, tag, k++);
        if (drp) begin
            push(4'b0001, tag, k++);
            push(4'b0000, tag, k++);
        end else begin
            for (int unsigned i = 0; i < hi; i++) push(4'b1100, tag, k++);
            for (int unsigned i = 0; i < lo; i++) push({2'b01, (i == 0), 1'b0}, tag, k++);
            push(4'b0000, tag, k++);
        end
    endtask

    task automatic push_str(input string s_sig, input string s_busy, input string s_done,
                            input string s_drop, input int unsigned tag);
        for (int unsigned i = 0; i < s_sig.len(); i++) begin
            push({s_sig[i] == 8'h31, s_busy[i] == 8'h31, s_done[i] == 8'h31, s_drop[i] == 8'h31},
                 tag, i);
        end
    endtask

    task automatic drain(input int unsigned tag);
        int unsigned k;
        k = 0;
        while (sb.size() > 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL seq%0d timeout: %0d frames left, want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic check(input string name, input logic [3:0] exp_v);
        n_tests++;
        if ({signal, busy, done, drop} !== exp_v) begin
            n_fail++;
            $display("FAIL %s: sig/busy/done/drop got %b want %b",
                     name, {signal, busy, done, drop}, exp_v);
        end
    endtask

    task automatic issue(input logic [7:0] w, input logic [7:0] g);
        @(posedge clk);
        #1;
        start = 1'b1;
        width = w;
        gap   = g;
    endtask

    task automatic release_start();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{w: 8'd3,   g: 8'd0,   hi: 3,   lo: 2,   drp: 1'b0};
        vecs[1] = '{w: 8'd1,   g: 8'd1,   hi: 2,   lo: 2,   drp: 1'b0};
        vecs[2] = '{w: 8'd0,   g: 8'd5,   hi: 0,   lo: 0,   drp: 1'b1};
        vecs[3] = '{w: 8'd2,   g: 8'd2,   hi: 2,   lo: 2,   drp: 1'b0};
        vecs[4] = '{w: 8'd5,   g: 8'd3,   hi: 5,   lo: 3,   drp: 1'b0};
        vecs[5] = '{w: 8'd2,   g: 8'd7,   hi: 2,   lo: 7,   drp: 1'b0};
        vecs[6] = '{w: 8'd0,   g: 8'd0,   hi: 0,   lo: 0,   drp: 1'b1};
        vecs[7] = '{w: 8'd255, g: 8'd255, hi: 255, lo: 255, drp: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        width = '0;
        gap   = '0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 8; i++) begin
            issue(vecs[i].w, vecs[i].g);
            push_pulse(vecs[i].hi, vecs[i].lo, vecs[i].drp, i);
            release_start();
            drain(i);
        end

        // Second request two cycles in, third one cycle later.
        issue(8'd3, 8'd0);
`ifdef PULSE_GEN_QUEUE_EN
        push_str("0111001111000", "0111111111110", "0000100000100", "0000100000000", 20);
`else
        push_str("0111000", "0111110", "0000100", "0001100", 20);
`endif
        release_start();
        issue(8'd4, 8'd0);
        issue(8'd6, 8'd0);
        release_start();
        drain(20);

        // Asynchronous reset in the middle of a width=10 pulse.
        issue(8'd10, 8'd0);
        release_start();
        #1 check("rst_pre", 4'b1100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 4'b0000);
        repeat (2) @(posedge clk);
        #1 check("rst_hold", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release", 4'b0000);

        issue(8'd10, 8'd0);
        push_pulse(10, 2, 1'b0, 30);
        release_start();
        drain(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
